// File: rtl/life_pkg.sv
// Shared state, op-code and status definitions for the Game-of-Life generation sequencer.
package life_pkg;

  localparam int unsigned DEFAULT_N = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStep,
    StCheck,
    StWait,
    StDone
  } state_e;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_RUN  = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_STABLE  = 2'b01;
  localparam logic [1:0] ST_EXTINCT = 2'b10;
  localparam logic [1:0] ST_HALTED  = 2'b11;

endpackage

// File: rtl/life_seq_if.sv
// Command port of the generation sequencer: valid/ready handshake plus op, count and pattern.
interface life_seq_if import life_pkg::*; #(
  parameter int unsigned N  = DEFAULT_N,
  parameter int unsigned CW = 16
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [CW-1:0]   cmd_count;
  logic [N*N-1:0]  cmd_pattern;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_count,
    output cmd_pattern,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_count,
    input  cmd_pattern,
    output cmd_ready
  );

endinterface

// File: rtl/life_rate_div.sv
// Down-counter that paces RUN: after start, expire rises once PERIOD-1 wait cycles have elapsed.
module life_rate_div #(
  parameter int unsigned PERIOD = 1
) (
  input  logic clk,
  input  logic _rst,
  input  logic start,
  output logic expire
);

  localparam int unsigned W    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int unsigned Load = (PERIOD > 1) ? PERIOD - 2 : 0;

  logic [W-1:0] cnt_q;

  // Loaded in CHECK so that expire is high in the last WAIT cycle.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= W'(Load);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/life_seq.sv
// Game-of-Life generation sequencer: drives load/step strobes, counts generations and
// detects extinct or still-life grids by comparing each generation with its predecessor.
module life_seq import life_pkg::*; #(
  parameter int unsigned N      = DEFAULT_N,
  parameter int unsigned CW     = 16,
  parameter int unsigned PERIOD = 1
) (
  input  logic            clk,
  input  logic            _rst,
  life_seq_if.slave       cmd,
  input  logic            halt,
  input  logic [N*N-1:0]  grid_state,
  output logic            load_en,
  output logic [N*N-1:0]  load_data,
  output logic            step_en,
  output logic [CW-1:0]   gen_count,
  output logic            busy,
  output logic            done,
  output logic [1:0]      status
);

  state_e          state_q;
  logic [N*N-1:0]  snap_q;
  logic [N*N-1:0]  load_data_q;
  logic [CW-1:0]   remain_q;
  logic [CW-1:0]   gen_q;
  logic            halt_pend_q;
  logic            load_en_q;
  logic            step_en_q;
  logic            done_q;
  logic [1:0]      status_q;
  logic            accept;
  logic            wait_expire;

  assign cmd.cmd_ready = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  life_rate_div #(
    .PERIOD (PERIOD)
  ) u_rate_div (
    .clk    (clk),
    ._rst   (_rst),
    .start  (state_q == StCheck),
    .expire (wait_expire)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q     <= StIdle;
      snap_q      <= '0;
      load_data_q <= '0;
      remain_q    <= '0;
      gen_q       <= '0;
      halt_pend_q <= 1'b0;
      load_en_q   <= 1'b0;
      step_en_q   <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_OK;
    end else begin
      if (halt && (state_q != StIdle)) begin
        halt_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            halt_pend_q <= 1'b0;
            load_data_q <= cmd.cmd_pattern;
            remain_q    <= (cmd.cmd_op == OP_STEP) ? CW'(1) : cmd.cmd_count;
            if (cmd.cmd_op == OP_LOAD) begin
              state_q   <= StLoad;
              load_en_q <= 1'b1;
            end else if ((cmd.cmd_op == OP_STEP) ||
                         ((cmd.cmd_op == OP_RUN) && (cmd.cmd_count != '0))) begin
              state_q   <= StStep;
              step_en_q <= 1'b1;
            end else begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              status_q <= ST_OK;
            end
          end
        end
        StLoad: begin
          load_en_q <= 1'b0;
          gen_q     <= '0;
          state_q   <= StDone;
          done_q    <= 1'b1;
          status_q  <= ST_OK;
        end
        StStep: begin
          // grid_state still holds the pre-step generation during this cycle.
          step_en_q <= 1'b0;
          snap_q    <= grid_state;
          remain_q  <= remain_q - 1'b1;
          if (gen_q != '1) begin
            gen_q <= gen_q + 1'b1;
          end
          state_q <= StCheck;
        end
        StCheck: begin
          if (grid_state == '0) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            status_q <= ST_EXTINCT;
          end else if (grid_state == snap_q) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            status_q <= ST_STABLE;
          end else if (halt_pend_q) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            status_q <= ST_HALTED;
          end else if (remain_q == '0) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            status_q <= ST_OK;
          end else if (PERIOD > 1) begin
            state_q <= StWait;
          end else begin
            state_q   <= StStep;
            step_en_q <= 1'b1;
          end
        end
        StWait: begin
          if (halt_pend_q) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            status_q <= ST_HALTED;
          end else if (wait_expire) begin
            state_q   <= StStep;
            step_en_q <= 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign load_en   = load_en_q;
  assign load_data = load_data_q;
  assign step_en   = step_en_q;
  assign gen_count = gen_q;
  assign done      = done_q;
  assign status    = status_q;

endmodule

// File: tb/tb_life_seq.sv
// Directed bench for life_seq: one instance with PERIOD=1 and one with PERIOD=4, each fed by
// a behavioural 8x8 Game-of-Life grid.
module tb_life_seq;
  import life_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 16;
  localparam logic [63:0] BLINKER = 64'h1C000000;
  localparam logic [63:0] BLOCK   = 64'h0303;
  localparam logic [63:0] DOT     = 64'h1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  life_seq_if #(.N(N), .CW(CW)) c1 ();
  life_seq_if #(.N(N), .CW(CW)) c4 ();

  logic            halt1, halt4;
  logic [N*N-1:0]  grid1, grid4, load_data1, load_data4;
  logic            load_en1, step_en1, busy1, done1;
  logic            load_en4, step_en4, busy4, done4;
  logic [CW-1:0]   gen1, gen4;
  logic [1:0]      status1, status4;

  life_seq #(.N(N), .CW(CW), .PERIOD(1)) u_dut1 (
    .clk(clk), ._rst(rst_n), .cmd(c1), .halt(halt1), .grid_state(grid1),
    .load_en(load_en1), .load_data(load_data1), .step_en(step_en1), .gen_count(gen1),
    .busy(busy1), .done(done1), .status(status1)
  );

  life_seq #(.N(N), .CW(CW), .PERIOD(4)) u_dut4 (
    .clk(clk), ._rst(rst_n), .cmd(c4), .halt(halt4), .grid_state(grid4),
    .load_en(load_en4), .load_data(load_data4), .step_en(step_en4), .gen_count(gen4),
    .busy(busy4), .done(done4), .status(status4)
  );

  // Next generation with dead cells beyond the border.
  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < 8) &&
                (c + dc >= 0) && (c + dc < 8)) begin
              cnt += int'(g[(r + dr) * 8 + c + dc]);
            end
          end
        end
        n[r * 8 + c] = (cnt == 3) || ((cnt == 2) && g[r * 8 + c]);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid1 <= '0;
      grid4 <= '0;
    end else begin
      if (load_en1) grid1 <= load_data1;
      else if (step_en1) grid1 <= life_next(grid1);
      if (load_en4) grid4 <= load_data4;
      else if (step_en4) grid4 <= life_next(grid4);
    end
  end

  int cyc = 0;
  int st1[$];
  int st4[$];
  int ndone1 = 0;
  int ndone4 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (step_en1) st1.push_back(cyc);
    if (step_en4) st4.push_back(cyc);
    if (done1) ndone1 <= ndone1 + 1;
    if (done4) ndone4 <= ndone4 + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int sel, input logic [1:0] op, input logic [CW-1:0] cnt,
                      input logic [N*N-1:0] pat, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    if (sel == 0) begin
      c1.cmd_op = op; c1.cmd_count = cnt; c1.cmd_pattern = pat; c1.cmd_valid = 1'b1;
    end else begin
      c4.cmd_op = op; c4.cmd_count = cnt; c4.cmd_pattern = pat; c4.cmd_valid = 1'b1;
    end
    while (!((sel == 0) ? c1.cmd_ready : c4.cmd_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept_in_time", 64'(t < 200), 64'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    c1.cmd_valid = 1'b0;
    c4.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int dcyc);
    int t;
    logic seen;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 500) begin
      @(negedge clk);
      seen = (sel == 0) ? done1 : done4;
      t++;
    end
    dcyc = cyc;
    check("done_in_time", 64'(seen), 64'd1);
  endtask

  task automatic wait_steps(input int sel, input int n);
    int t;
    t = 0;
    while (((sel == 0) ? st1.size() : st4.size()) < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("steps_in_time", 64'(t < 500), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, d, nd, t;
    c1.cmd_valid = 1'b0; c1.cmd_op = OP_NOP; c1.cmd_count = '0; c1.cmd_pattern = '0;
    c4.cmd_valid = 1'b0; c4.cmd_op = OP_NOP; c4.cmd_count = '0; c4.cmd_pattern = '0;
    halt1 = 1'b0;
    halt4 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(c1.cmd_ready), 64'd1);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_load_en", 64'(load_en1), 64'd0);
    check("rst_step_en", 64'(step_en1), 64'd0);
    check("rst_load_data", load_data1, 64'd0);
    check("rst_gen", 64'(gen1), 64'd0);
    check("rst_status", 64'(status1), 64'(ST_OK));
    check("rst_ready4", 64'(c4.cmd_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(c1.cmd_ready), 64'd1);

    // LOAD timing: load_en at k+1, done at k+2, ready at k+3
    send(0, OP_LOAD, 16'd0, BLINKER, a);
    @(negedge clk);
    check("load_en_k1", 64'(load_en1), 64'd1);
    check("load_data_k1", load_data1, BLINKER);
    check("busy_k1", 64'(busy1), 64'd1);
    check("not_ready_k1", 64'(c1.cmd_ready), 64'd0);
    @(negedge clk);
    check("load_done_k2", 64'(done1), 64'd1);
    check("load_en_k2", 64'(load_en1), 64'd0);
    check("load_gen", 64'(gen1), 64'd0);
    check("load_status", 64'(status1), 64'(ST_OK));
    @(negedge clk);
    check("load_ready_k3", 64'(c1.cmd_ready), 64'd1);
    check("load_done_once", 64'(done1), 64'd0);

    // Blinker RUN 4 with PERIOD=1
    st1.delete();
    send(0, OP_RUN, 16'd4, '0, a);
    wait_done(0, d);
    check("run4_steps", 64'(st1.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("run4_step%0d_cycle", i), 64'((i < st1.size()) ? st1[i] : -1),
            64'(a + 2 * i));
    end
    check("run4_done_cycle", 64'(d), 64'(a + 8));
    check("run4_status", 64'(status1), 64'(ST_OK));
    check("run4_gen", 64'(gen1), 64'd4);
    check("run4_grid", grid1, BLINKER);

    // Block: still life after one step
    send(0, OP_LOAD, 16'd0, BLOCK, a);
    wait_done(0, d);
    st1.delete();
    send(0, OP_RUN, 16'd10, '0, a);
    wait_done(0, d);
    check("block_steps", 64'(st1.size()), 64'd1);
    check("block_done_cycle", 64'(d), 64'(a + 2));
    check("block_status", 64'(status1), 64'(ST_STABLE));
    check("block_gen", 64'(gen1), 64'd1);

    // Lone cell dies; a further STEP on the empty grid is extinct too
    send(0, OP_LOAD, 16'd0, DOT, a);
    wait_done(0, d);
    st1.delete();
    send(0, OP_RUN, 16'd5, '0, a);
    wait_done(0, d);
    check("dot_steps", 64'(st1.size()), 64'd1);
    check("dot_status", 64'(status1), 64'(ST_EXTINCT));
    check("dot_gen", 64'(gen1), 64'd1);
    st1.delete();
    send(0, OP_STEP, 16'd0, '0, a);
    wait_done(0, d);
    check("step_en_k1", 64'((st1.size() > 0) ? st1[0] : -1), 64'(a));
    check("step_done_k3", 64'(d), 64'(a + 2));
    check("step_status", 64'(status1), 64'(ST_EXTINCT));
    check("step_gen", 64'(gen1), 64'd2);

    // RUN 0 finishes without stepping
    st1.delete();
    send(0, OP_RUN, 16'd0, '0, a);
    wait_done(0, d);
    check("run0_done_cycle", 64'(d), 64'(a));
    check("run0_steps", 64'(st1.size()), 64'd0);
    check("run0_status", 64'(status1), 64'(ST_OK));
    check("run0_gen", 64'(gen1), 64'd2);

    // A command held valid during RUN is taken only once ready returns
    send(0, OP_LOAD, 16'd0, BLINKER, a);
    wait_done(0, d);
    st1.delete();
    send(0, OP_RUN, 16'd3, '0, a);
    nd = ndone1;
    send(0, OP_LOAD, 16'd0, BLOCK, b);
    check("held_accept_cycle", 64'(b), 64'(a + 8));
    check("held_run_steps", 64'(st1.size()), 64'd3);
    check("held_run_done", 64'(ndone1 - nd), 64'd1);
    check("held_run_status", 64'(status1), 64'(ST_OK));
    wait_done(0, d);
    check("held_load_gen", 64'(gen1), 64'd0);
    check("held_load_grid", grid1, BLOCK);

    // PERIOD=4: halt pulse in the third WAIT stops the run after three steps
    send(1, OP_LOAD, 16'd0, BLINKER, a);
    wait_done(1, d);
    st4.delete();
    send(1, OP_RUN, 16'd100, '0, a);
    wait_steps(1, 3);
    @(negedge clk);
    halt4 = 1'b1;
    @(negedge clk);
    halt4 = 1'b0;
    wait_done(1, d);
    check("halt_step1_cycle", 64'((st4.size() > 1) ? st4[1] : -1), 64'(a + 5));
    check("halt_step2_cycle", 64'((st4.size() > 2) ? st4[2] : -1), 64'(a + 10));
    check("halt_done_cycle", 64'(d), 64'(a + 14));
    check("halt_status", 64'(status4), 64'(ST_HALTED));
    check("halt_gen", 64'(gen4), 64'd3);
    repeat (10) @(negedge clk);
    check("halt_no_fourth_step", 64'(st4.size()), 64'd3);

    // Reset in the middle of a run
    st4.delete();
    send(1, OP_RUN, 16'd100, '0, a);
    nd = ndone4;
    wait_steps(1, 1);
    t = 0;
    while (!step_en4 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("mid_run_step_seen", 64'(step_en4), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_step_en", 64'(step_en4), 64'd0);
    check("mrst_busy", 64'(busy4), 64'd0);
    check("mrst_ready", 64'(c4.cmd_ready), 64'd1);
    check("mrst_gen", 64'(gen4), 64'd0);
    check("mrst_status", 64'(status4), 64'(ST_OK));
    check("mrst_load_data", load_data4, 64'd0);
    check("mrst_done", 64'(done4), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mrst_no_done", 64'(ndone4 - nd), 64'd0);
    check("mrst_no_more_steps", 64'(st4.size()), 64'd1);
    check("mrst_ready_after", 64'(c4.cmd_ready), 64'd1);
    check("mrst_idle_after", 64'(busy4), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
